// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Brief    : Bit-serial adder. One full-adder slice per clock, LSB first,
//             carry held in a single flop. IDLE -> RUN (WIDTH edges) -> DONE.
//  Revision : 1.0  initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             saClk,
    input  logic             saRstN,
    input  logic             saStart,
    input  logic [WIDTH-1:0] saOp1,
    input  logic [WIDTH-1:0] saOp2,
    input  logic             saCi,
    output logic [WIDTH-1:0] saRes,
    output logic             saCo,
    output logic             saBusy,
    output logic             saDone
);

    // Counter holds 0..WIDTH-1 with headroom, so it never wraps inside a RUN.
    localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               co_q, co_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               w_bit_sum;
    logic               w_bit_carry;
    logic               w_last_bit;

    // Next-state logic: full-adder slice on the current LSBs plus FSM sequencing.
    always_comb begin
        w_bit_sum   = op_a_q[0] ^ op_b_q[0] ^ carry_q;
        w_bit_carry = (op_a_q[0] & op_b_q[0]) | (carry_q & (op_a_q[0] ^ op_b_q[0]));
        w_last_bit  = (cnt_q == c_LAST);

        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        co_d    = co_q;

        case (state_q)
            ST_IDLE: begin
                if (saStart) begin
                    op_a_d  = saOp1;
                    op_b_d  = saOp2;
                    carry_d = saCi;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                op_a_d  = {1'b0, op_a_q[WIDTH-1:1]};
                op_b_d  = {1'b0, op_b_q[WIDTH-1:1]};
                sum_d   = {w_bit_sum, sum_q[WIDTH-1:1]};
                carry_d = w_bit_carry;
                cnt_d   = cnt_q + c_ONE;
                if (w_last_bit) begin
                    // Publish the result including the bit computed on this edge.
                    res_d   = {w_bit_sum, sum_q[WIDTH-1:1]};
                    co_d    = w_bit_carry;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are registered versions of the state being entered.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge saClk or negedge saRstN) begin
        if (!saRstN) begin
            state_q <= ST_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign saRes  = res_q;
    assign saCo   = co_q;
    assign saBusy = busy_q;
    assign saDone = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Brief    : Self-checking bench for serial_adder (WIDTH=8): transaction-level
//             reference model compared every cycle, plus literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_adder;

    localparam int W = 8;

    logic         saClk = 1'b0;
    logic         saRstN;
    logic         saStart;
    logic [W-1:0] saOp1;
    logic [W-1:0] saOp2;
    logic         saCi;
    logic [W-1:0] saRes;
    logic         saCo;
    logic         saBusy;
    logic         saDone;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .saClk  (saClk),
        .saRstN (saRstN),
        .saStart(saStart),
        .saOp1  (saOp1),
        .saOp2  (saOp2),
        .saCi   (saCi),
        .saRes  (saRes),
        .saCo   (saCo),
        .saBusy (saBusy),
        .saDone (saDone)
    );

    // Free-running clock, period 10.
    always #5 saClk = ~saClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an accepted request yields its arithmetic sum
    // WIDTH edges later, followed by one done cycle, then idle.
    int           m_left = 0;
    bit           m_done = 1'b0;
    logic [W-1:0] m_res  = '0;
    bit           m_co   = 1'b0;
    logic [W:0]   m_pend = '0;

    always @(posedge saClk or negedge saRstN) begin
        if (!saRstN) begin
            m_left = 0;
            m_done = 1'b0;
            m_res  = '0;
            m_co   = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_done        = 1'b1;
                {m_co, m_res} = m_pend;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (saStart === 1'b1) begin
            m_pend = {1'b0, saOp1} + {1'b0, saOp2} + (W+1)'(saCi);
            m_left = W;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge saClk) begin
        if (cmp_en) begin
            check("busy", 32'(saBusy), 32'(m_left > 0));
            check("done", 32'(saDone), 32'(m_done));
            check("res",  32'(saRes),  32'(m_res));
            check("co",   32'(saCo),   32'(m_co));
        end
    end

    // Wait (bounded) for saDone; returns the number of negedges waited.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (saDone !== 1'b1 && cyc < 40) begin
            @(negedge saClk);
            cyc++;
        end
        if (saDone !== 1'b1) check("done_timeout", 32'(saDone), 32'd1);
    endtask

    task automatic do_add(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic [W-1:0] exp_res, input logic exp_co);
        int cyc;
        @(negedge saClk);
        saStart = 1'b1;
        saOp1   = a;
        saOp2   = b;
        saCi    = ci;
        @(negedge saClk);
        // Scramble inputs after acceptance: the running addition must not see them.
        saStart = 1'b0;
        saOp1   = W'($urandom);
        saOp2   = W'($urandom);
        saCi    = 1'($urandom);
        wait_done(cyc);
        check({name, "_latency"}, 32'(cyc), 32'(W));
        check({name, "_res"}, 32'(saRes), 32'(exp_res));
        check({name, "_co"},  32'(saCo),  32'(exp_co));
        @(negedge saClk);
    endtask

    initial begin
        int cyc;
        saRstN  = 1'b0;
        saStart = 1'b0;
        saOp1   = '0;
        saOp2   = '0;
        saCi    = 1'b0;
        repeat (3) @(negedge saClk);
        check("rst_res",  32'(saRes),  32'd0);
        check("rst_co",   32'(saCo),   32'd0);
        check("rst_busy", 32'(saBusy), 32'd0);
        check("rst_done", 32'(saDone), 32'd0);
        cmp_en = 1'b1;
        saRstN = 1'b1;

        // Basic sums and carry boundaries.
        do_add("zero",  8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        do_add("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        do_add("7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
        do_add("a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
        do_add("c3_3c", 8'hC3, 8'h3C, 1'b1, 8'h00, 1'b1);

        // Start request and operand change during RUN must be ignored.
        @(negedge saClk);
        saStart = 1'b1; saOp1 = 8'h12; saOp2 = 8'h34; saCi = 1'b0;
        @(negedge saClk);                 // RUN cycle 1
        saStart = 1'b0;
        @(negedge saClk);                 // RUN cycle 2
        @(negedge saClk);                 // RUN cycle 3
        saStart = 1'b1; saOp1 = 8'hFF; saOp2 = 8'hFF;
        @(negedge saClk);                 // RUN cycle 4
        saStart = 1'b0; saOp1 = 8'hFF;
        wait_done(cyc);
        check("ignore_latency", 32'(cyc), 32'(W - 3));
        check("ignore_res", 32'(saRes), 32'h46);
        check("ignore_co",  32'(saCo),  32'd0);
        @(negedge saClk);

        // Start held high: back-to-back additions with one idle cycle between.
        @(negedge saClk);
        saStart = 1'b1; saOp1 = 8'h01; saOp2 = 8'h02; saCi = 1'b0;
        wait_done(cyc);
        check("b2b_first_latency", 32'(cyc), 32'(W + 1));
        check("b2b_res0", 32'(saRes), 32'h03);
        for (int i = 1; i < 3; i++) begin
            @(negedge saClk);
            wait_done(cyc);
            check("b2b_gap", 32'(cyc), 32'(W + 1));
            check("b2b_res", 32'(saRes), 32'h03);
            check("b2b_co",  32'(saCo),  32'd0);
        end
        @(negedge saClk);
        saStart = 1'b0;
        repeat (2) @(negedge saClk);

        // Asynchronous reset in the middle of a RUN.
        saStart = 1'b1; saOp1 = 8'hF0; saOp2 = 8'h0F; saCi = 1'b0;
        @(negedge saClk);                 // RUN cycle 1
        saStart = 1'b0;
        repeat (4) @(negedge saClk);      // RUN cycle 5
        #2 saRstN = 1'b0;
        #1;
        check("arst_res",  32'(saRes),  32'd0);
        check("arst_co",   32'(saCo),   32'd0);
        check("arst_busy", 32'(saBusy), 32'd0);
        check("arst_done", 32'(saDone), 32'd0);
        repeat (3) @(negedge saClk);
        saRstN = 1'b1;
        do_add("post_rst", 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0);

        repeat (2) @(negedge saClk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port saClk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port saRstN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port saStart  input  1  request to begin one addition; sampled on rising edge.
REQ-005 SHALL have port saOp1  input  WIDTH  first operand; sampled only with an accepted saStart.
REQ-006 SHALL have port saOp2  input  WIDTH  second operand; sampled only with an accepted saStart.
REQ-007 SHALL have port saCi  input  1  carry-in; sampled only with an accepted saStart.
REQ-008 SHALL have port saRes  output  WIDTH  registered sum of the last completed addition.
REQ-009 SHALL have port saCo  output  1  registered carry-out of the last completed addition.
REQ-010 SHALL have port saBusy  output  1  high while an addition is in progress.
REQ-011 SHALL have port saDone  output  1  one-cycle pulse marking that saRes/saCo have just updated.

Function
REQ-012 SHALL implement a bit-serial adder: one full-adder bit slice evaluated per clock, LSB first, with the carry held in a single flip-flop between bits.
REQ-013 SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE: saStart=1 at a rising edge SHALL load saOp1/saOp2 into internal shift registers, load saCi into the carry flop, clear the bit counter to 0, and enter RUN.
REQ-015 RUN: each rising edge SHALL compute sum=a0^b0^c and carry=(a0&b0)|(c&(a0^b0)) on the current LSBs a0/b0 and carry c, shift both operand registers right by one, shift sum into the MSB of an internal result register, update the carry flop, and increment the counter.
REQ-016 RUN SHALL last exactly WIDTH edges; the edge that processes bit WIDTH-1 SHALL copy the internal result register (including that final bit) to saRes, the final carry to saCo, and enter DONE.
REQ-017 DONE SHALL last exactly one cycle, with saDone=1, then return to IDLE unconditionally.
REQ-018 Latency: if saStart is accepted at edge k, saDone SHALL be high during the cycle after edge k+WIDTH, and saRes/saCo SHALL be valid from that cycle onward.
REQ-019 saBusy SHALL be 1 exactly while in RUN; saDone SHALL be 1 exactly while in DONE.
REQ-020 saRes and saCo SHALL change only on the RUN-to-DONE edge and SHALL hold their values in IDLE, RUN and DONE otherwise.
REQ-021 saStart asserted in RUN or DONE SHALL be ignored (no restart, no operand reload); saStart held high continuously SHALL start a new addition on the first edge in IDLE.
REQ-022 Changes on saOp1/saOp2/saCi after the accepting edge SHALL NOT affect the running addition.
REQ-023 Result SHALL equal (saOp1+saOp2+saCi) mod 2^WIDTH, with saCo equal to bit WIDTH of the full sum.
REQ-024 The bit counter SHALL be sized ceil(log2(WIDTH))+1 bits and SHALL NOT wrap during a RUN.

Reset
REQ-025 saRstN=0 SHALL immediately, regardless of the clock, force state IDLE and set saRes=0, saCo=0, saBusy=0, saDone=0, counter=0, carry flop=0, and operand/result shift registers=0.
REQ-026 Reset asserted mid-RUN SHALL abort the addition with no saDone pulse and no update of saRes/saCo beyond the reset value 0.
REQ-027 After saRstN deasserts, the first rising edge with saStart=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-028 Start with op1=8'h00, op2=8'h00, ci=0 -> saBusy high 8 cycles, saDone pulse 1 cycle, saRes=8'h00, saCo=0.
REQ-029 Start with op1=8'hFF, op2=8'h01, ci=0 -> saRes=8'h00, saCo=1; op1=8'h7F, op2=8'h01, ci=0 -> saRes=8'h80, saCo=0.
REQ-030 Start with op1=8'hA5, op2=8'h5A, ci=1 -> saRes=8'h00, saCo=1; saDone exactly in the cycle after edge k+8.
REQ-031 Start with op1=8'h12, op2=8'h34, ci=0, then pulse saStart with op1=8'hFF, op2=8'hFF at RUN cycle 3 and change op1 to 8'hFF at RUN cycle 4 -> request ignored, result saRes=8'h46, saCo=0.
REQ-032 Hold saStart high with fixed operands 8'h01/8'h02/0 -> back-to-back additions, saRes=8'h03 each, one idle cycle between DONE and next RUN.
REQ-033 Assert saRstN=0 at RUN cycle 5 of 8'hF0+8'h0F -> outputs 0 asynchronously, no saDone pulse; a new start after release completes with saRes=8'hFF, saCo=0.
